// File: rtl/nonoverlapping_template_param.sv
`default_nettype none
// ============================================================================
// Module   : nonoverlapping_template_param
// Brief    : Non-overlapping template matching randomness test. Counts
//            template hits per block and accumulates a scaled chi-square
//            statistic with a pass/fail verdict per sequence.
// Revision : 1.0 - initial release
// ============================================================================
module nonoverlapping_template_param #(
  parameter int N_BLOCKS  = 8,
  parameter int BLOCK_LEN = 256,
  parameter int TMPL_LEN  = 4,
  parameter int MU        = 253,
  parameter int R_SHIFT   = 4,
  parameter int U_THRESH  = 46288,
  parameter int STAT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cont_mode,
  input  logic [TMPL_LEN-1:0] template,
  input  logic                rand_bit,
  input  logic                rand_valid,
  output logic                rand_ready,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [STAT_W-1:0]   chi_sqr
);

  localparam int c_bit_w  = $clog2(BLOCK_LEN);
  localparam int c_blk_w  = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
  localparam int c_fill_w = $clog2(TMPL_LEN);
  localparam int c_mc_w   = $clog2(BLOCK_LEN / TMPL_LEN + 1);
  localparam int c_d_w    = c_mc_w + R_SHIFT + 2;
  localparam int c_sq_w   = 2 * c_d_w;
  localparam int c_sum_w  = (c_sq_w > STAT_W) ? c_sq_w : STAT_W;

  localparam logic [c_bit_w-1:0]     c_last_bit = c_bit_w'(BLOCK_LEN - 1);
  localparam logic [c_blk_w-1:0]     c_last_blk = c_blk_w'(N_BLOCKS - 1);
  localparam logic [c_fill_w-1:0]    c_fill_max = c_fill_w'(TMPL_LEN - 1);
  localparam logic signed [c_d_w-1:0] c_mu      = c_d_w'(MU);
  localparam logic [STAT_W-1:0]      c_thresh   = STAT_W'(U_THRESH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_ACCUM  = 2'd2,
    S_DECIDE = 2'd3
  } state_t;

  state_t                r_state;
  logic [TMPL_LEN-1:0]   r_tmpl;
  logic                  r_cont;
  logic [TMPL_LEN-2:0]   r_win;
  logic [c_fill_w-1:0]   r_fill;
  logic [c_bit_w-1:0]    r_bit_cnt;
  logic [c_blk_w-1:0]    r_blk_cnt;
  logic [c_mc_w-1:0]     r_match_cnt;
  logic [STAT_W-1:0]     r_accum;
  logic [STAT_W-1:0]     r_chi;
  logic                  r_pass;
  logic                  r_done;

  logic                  w_accept;
  logic [TMPL_LEN-1:0]   w_win_next;
  logic                  w_match;
  logic signed [c_d_w-1:0]  w_scaled;
  logic signed [c_d_w-1:0]  w_d;
  logic signed [c_sq_w-1:0] w_sq;
  logic [c_sum_w-1:0]    w_sum;

  assign w_accept   = rand_valid && rand_ready;
  assign w_win_next = {r_win, rand_bit};
  // A hit needs m fresh bits since the last hit or block start.
  assign w_match    = (r_fill == c_fill_max) && (w_win_next == r_tmpl);

  assign w_scaled = c_d_w'(r_match_cnt) << R_SHIFT;
  assign w_d      = w_scaled - c_mu;
  assign w_sq     = w_d * w_d;
  assign w_sum    = c_sum_w'(r_accum) + c_sum_w'($unsigned(w_sq));

  assign rand_ready = (r_state == S_RUN);
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign pass       = r_pass;
  assign chi_sqr    = r_chi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_tmpl      <= '0;
      r_cont      <= 1'b0;
      r_win       <= '0;
      r_fill      <= '0;
      r_bit_cnt   <= '0;
      r_blk_cnt   <= '0;
      r_match_cnt <= '0;
      r_accum     <= '0;
      r_chi       <= '0;
      r_pass      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_tmpl      <= template;
            r_cont      <= cont_mode;
            r_win       <= '0;
            r_fill      <= '0;
            r_bit_cnt   <= '0;
            r_blk_cnt   <= '0;
            r_match_cnt <= '0;
            r_accum     <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_match) begin
              r_match_cnt <= r_match_cnt + 1'b1;
              r_fill      <= '0;
              r_win       <= '0;
            end else begin
              r_win <= w_win_next[TMPL_LEN-2:0];
              if (r_fill != c_fill_max) begin
                r_fill <= r_fill + 1'b1;
              end
            end
            // Block end overrides the window so no match straddles blocks.
            if (r_bit_cnt == c_last_bit) begin
              r_bit_cnt <= '0;
              r_fill    <= '0;
              r_win     <= '0;
              r_state   <= S_ACCUM;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_ACCUM: begin
          r_accum     <= w_sum[STAT_W-1:0];
          r_match_cnt <= '0;
          if (r_blk_cnt == c_last_blk) begin
            r_state <= S_DECIDE;
          end else begin
            r_blk_cnt <= r_blk_cnt + 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_DECIDE: begin
          r_chi     <= r_accum;
          r_pass    <= (r_accum <= c_thresh);
          r_done    <= 1'b1;
          r_accum   <= '0;
          r_blk_cnt <= '0;
          r_state   <= r_cont ? S_RUN : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nonoverlapping_template_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonoverlapping_template_param
// Brief    : Self-checking bench for nonoverlapping_template_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonoverlapping_template_param;

  localparam int NB   = 8;
  localparam int BL   = 256;
  localparam int M    = 4;
  localparam int SEQ  = NB * BL;
  localparam int MU_S = 253;
  localparam int RS   = 4;
  localparam int UT   = 46288;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        cont_mode = 1'b0;
  logic [3:0]  template = 4'd0;
  logic        rand_bit = 1'b0;
  logic        rand_valid = 1'b0;
  logic        rand_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] chi_sqr;

  always #5 clk = ~clk;

  nonoverlapping_template_param dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont_mode  (cont_mode),
    .template   (template),
    .rand_bit   (rand_bit),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .chi_sqr    (chi_sqr)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_low = 0;
  logic stim [0:4*SEQ-1];
  int          done_cyc [$];
  logic [31:0] done_chi [$];
  logic        done_pass [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cyc.push_back(cyc);
      done_chi.push_back(chi_sqr);
      done_pass.push_back(pass);
    end
    if (busy && !rand_ready) ready_low = ready_low + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: scan each block left to right, skipping m bits after a hit.
  function automatic void model(input int base, input logic [3:0] tm,
                                output longint chi, output logic ps);
    int cnt;
    int i;
    int d;
    logic [3:0] w;
    chi = 0;
    for (int b = 0; b < NB; b++) begin
      cnt = 0;
      i = 0;
      while (i <= BL - M) begin
        for (int j = 0; j < M; j++) w[M-1-j] = stim[base + b*BL + i + j];
        if (w == tm) begin
          cnt++;
          i += M;
        end else begin
          i++;
        end
      end
      d = cnt * (1 << RS) - MU_S;
      chi += longint'(d * d);
    end
    ps = (chi <= UT);
  endfunction

  function automatic void build(input int kind, input int base);
    int p;
    for (int i = 0; i < SEQ; i++) begin
      p = i % BL;
      case (kind)
        0: stim[base+i] = ((i % 16) == 12) || ((i % 16) == 13);
        1: stim[base+i] = 1'b1;
        2: stim[base+i] = 1'b0;
        3: stim[base+i] = 1'($urandom_range(0, 1));
        default: stim[base+i] = (p == 254) || (p == 255) || (p == 100) || (p == 101);
      endcase
    end
  endfunction

  task automatic feed(input string nm, input int base, input int nbits, input int duty);
    int idx;
    int guard;
    logic acc;
    idx = 0;
    guard = 0;
    while (idx < nbits && guard < nbits * 20 + 100) begin
      rand_valid = ($urandom_range(0, 99) < duty);
      rand_bit   = stim[base + idx];
      @(negedge clk);
      acc = rand_valid && rand_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    rand_valid = 1'b0;
    if (idx < nbits) chk({nm, "_feed_timeout"}, idx, nbits);
  endtask

  task automatic pulse_start(input logic [3:0] tm, input logic cm);
    @(posedge clk);
    #1;
    template  = tm;
    cont_mode = cm;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    template  = ~tm;
    cont_mode = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0]  tm;
    logic [2:0]  kind;
    logic [6:0]  duty;
    logic [31:0] chi;
    logic        ps;
    logic        use_model;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat;
    int n0;
    int rl0;
    longint mchi;
    logic mps;
    logic [31:0] echi;
    logic eps;
    string nm;

    vecs[0] = '{4'b1100, 3'd0, 7'd100, 32'd72,      1'b1, 1'b0};
    vecs[1] = '{4'b1111, 3'd1, 7'd100, 32'd4755528, 1'b0, 1'b0};
    vecs[2] = '{4'b1100, 3'd2, 7'd100, 32'd512072,  1'b0, 1'b0};
    vecs[3] = '{4'b1100, 3'd4, 7'd100, 32'd449352,  1'b0, 1'b0};
    vecs[4] = '{4'b1100, 3'd0, 7'd30,  32'd72,      1'b1, 1'b0};
    vecs[5] = '{4'b1011, 3'd3, 7'd70,  32'd0,       1'b0, 1'b1};
    vecs[6] = '{4'b0001, 3'd3, 7'd70,  32'd0,       1'b0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rand_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_chi", chi_sqr, 0);
    #1;
    rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      nm = $sformatf("v%0d", v);
      build(int'(vecs[v].kind), 0);
      if (vecs[v].use_model) begin
        model(0, vecs[v].tm, mchi, mps);
        echi = 32'(mchi);
        eps  = mps;
      end else begin
        echi = vecs[v].chi;
        eps  = vecs[v].ps;
      end
      n0  = done_cyc.size();
      rl0 = ready_low;
      pulse_start(vecs[v].tm, 1'b0);
      feed(nm, 0, SEQ, int'(vecs[v].duty));
      lat = 0;
      while (!done && lat < 6) begin
        @(negedge clk);
        #1;
        if (!done) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
      chk({nm, "_latency"}, lat, 2);
      chk({nm, "_chi"}, chi_sqr, echi);
      chk({nm, "_pass"}, pass, eps);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk({nm, "_done_width"}, done, 0);
      chk({nm, "_idle"}, busy, 0);
      chk({nm, "_pulses"}, done_cyc.size() - n0, 1);
      chk({nm, "_ready_low"}, ready_low - rl0, NB + 1);
    end

    // Continuous mode: three sequences back to back, then reset mid-block.
    build(3, 0);
    build(3, SEQ);
    build(3, 2*SEQ);
    build(3, 3*SEQ);
    n0 = done_cyc.size();
    pulse_start(4'b1010, 1'b1);
    feed("cont", 0, 3*SEQ, 100);
    lat = 0;
    while (done_cyc.size() - n0 < 3 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("cont_pulses", done_cyc.size() - n0, 3);
    if (done_cyc.size() - n0 >= 3) begin
      for (int s = 0; s < 3; s++) begin
        model(s*SEQ, 4'b1010, mchi, mps);
        chk($sformatf("cont%0d_chi", s), done_chi[n0+s], 32'(mchi));
        chk($sformatf("cont%0d_pass", s), done_pass[n0+s], mps);
        if (s > 0) chk($sformatf("cont%0d_spacing", s),
                       done_cyc[n0+s] - done_cyc[n0+s-1], SEQ + NB + 1);
      end
    end
    chk("cont_still_busy", busy, 1);
    feed("cont4", 3*SEQ, 100, 100);
    n0 = done_cyc.size();
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", rand_ready, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_chi", chi_sqr, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    chk("abort_no_done", done_cyc.size() - n0, 0);
    chk("abort_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
